// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment driver for an MM:SS BCD clock.
// Scans one digit per slot and snapshots the digits once per frame so that a
// frame never mixes old and new values. It blinks the field being adjusted,
// can blank a leading minute zero, and lights DP after digit 2 as the MM.SS
// separator.
module seg7_scan #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_ten,
    input  logic [3:0] min_one,
    input  logic [3:0] sec_ten,
    input  logic [3:0] sec_one,
    input  logic       adj_min,
    input  logic       adj_sec,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    // Idle (all-off) pin levels. These are also the reset levels of the pins.
    localparam logic [3:0] AN_OFF  = {4{AN_ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};

    // Slot and frame timing.
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               scan_wrap;

    // Free-running blink timebase.
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;

    // Per-frame digit snapshot. Index 3 is min_ten and index 0 is sec_one.
    logic [3:0][3:0]    snap_q, snap_d;

    // Registered pins.
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    // Internal active-high view of the pins before the polarity is applied.
    logic [3:0]         cur_digit;
    logic               guard;
    logic               blank;
    logic [3:0]         an_act;
    logic [6:0]         seg_act;
    logic               dp_act;

    // BCD to segments {g,f,e,d,c,b,a}, active-high. Non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        logic [6:0] s;
        s = 7'h40;
        case (bcd)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Next-state logic for the scan counter, the digit index, the frame snapshot and blinking.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;

        scan_wrap = (scan_cnt_q == SCAN_MAX);
        if (scan_wrap) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
            // Latch all digits together as the frame restarts at digit 0.
            if (idx_q == 2'd3) begin
                snap_d = {min_ten, min_one, sec_ten, sec_one};
            end
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end

        if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
    end

    // Pin values for the current slot. They are registered on the next edge, which gives one cycle of latency.
    always_comb begin
        cur_digit = snap_q[idx_q];
        guard     = (scan_cnt_q == '0);
        blank     = (adj_sec  && blink_ph_q && !idx_q[1])
                 || (adj_min  && blink_ph_q &&  idx_q[1])
                 || (blank_lz && (idx_q == 2'd3) && (snap_q[3] == 4'd0));

        an_act  = guard ? 4'b0000 : (4'b0001 << idx_q);
        seg_act = (guard || blank) ? 7'h00 : decode(cur_digit);
        dp_act  = !guard && (idx_q == 2'd2) && !blank;

        an_d  = AN_ACTIVE_LOW  ? ~an_act  : an_act;
        seg_d = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_act  : dp_act;
    end

    // State and output registers. All of them return to their reset values asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            // NOTE: the snapshot is a few flops rather than a RAM, so resetting it is cheap and gives a defined first frame.
            snap_q      <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= SEG_ACTIVE_LOW;
        end else begin
            // NOTE: non-blocking updates let every flop sample the values from before this edge.
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
